riscv_dmi_frontend: RTL

Debug-module-side DMI front-end. It sits directly downstream of the DTM and consumes its DMI request/response handshake, converting each DMI transaction into one access on a simple DM register bus. It returns read data and a DMI status op to the DTM. It runs on the DM system clock, single clock domain; any CDC is external.

---
 rtl/riscv_dmi_frontend.sv | 124 ++++++++++++
 1 files changed

// File: rtl/riscv_dmi_frontend.sv
// riscv_dmi_frontend: DMI request/response front-end driving a DM register bus; RISCV_DMI_FRONTEND_TIMEOUT_EN adds an access timeout
package riscv_dm_pkg;
  localparam int DMI_ADDR_WIDTH = 7;
  localparam int DMI_DATA_WIDTH = 32;
  localparam int DMI_OP_WIDTH = 2;
  localparam logic [1:0] DMI_OP_NOP = 2'd0;
  localparam logic [1:0] DMI_OP_READ = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;
  localparam logic [1:0] DMI_OP_RSVD = 2'd3;
  localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED = 2'd2;
endpackage

module riscv_dmi_frontend #(
  parameter int ADDR_WIDTH = riscv_dm_pkg::DMI_ADDR_WIDTH,
  parameter int DATA_WIDTH = riscv_dm_pkg::DMI_DATA_WIDTH,
  parameter int OP_WIDTH = riscv_dm_pkg::DMI_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [OP_WIDTH-1:0]   req_op_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic [OP_WIDTH-1:0]   resp_op_o,
  output logic                  reg_req_o,
  output logic                  reg_we_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  input  logic                  reg_gnt_i,
  input  logic                  reg_rvalid_i,
  input  logic [DATA_WIDTH-1:0] reg_rdata_i,
  input  logic                  reg_err_i
);
  import riscv_dm_pkg::*;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [OP_WIDTH-1:0] OP_NOP = OP_WIDTH'(DMI_OP_NOP);
  localparam logic [OP_WIDTH-1:0] OP_READ = OP_WIDTH'(DMI_OP_READ);
  localparam logic [OP_WIDTH-1:0] OP_WRITE = OP_WIDTH'(DMI_OP_WRITE);
  localparam logic [OP_WIDTH-1:0] RESP_OK = OP_WIDTH'(DMI_RESP_SUCCESS);
  localparam logic [OP_WIDTH-1:0] RESP_FAIL = OP_WIDTH'(DMI_RESP_FAILED);

  state_t state, state_n;
  logic [OP_WIDTH-1:0] op_q, resp_op_n, cpl_op;
  logic [DATA_WIDTH-1:0] resp_data_n, cpl_data;
  logic accept, done, timeout;

  assign req_ready_o = (state == IDLE) & ~rst_i;
  assign resp_valid_o = state == RESP;
  assign reg_req_o = state == ACCESS;
  assign reg_we_o = (state == ACCESS) & (op_q == OP_WRITE);
  assign accept = req_valid_i & req_ready_o;
  assign done = ((state == ACCESS) & reg_gnt_i & reg_rvalid_i) | ((state == WAIT) & reg_rvalid_i);
  assign cpl_op = reg_err_i ? RESP_FAIL : RESP_OK;
  assign cpl_data = ((op_q == OP_READ) & ~reg_err_i) ? reg_rdata_i : '0;

`ifdef RISCV_DMI_FRONTEND_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign timeout = ((state == ACCESS) | (state == WAIT)) & (cnt == CW'(TIMEOUT_CYCLES));
  // access-age counter: restarts on each new bus access, runs while the access is open
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else if ((state == ACCESS) | (state == WAIT)) cnt <= cnt + CW'(1);
  end
`else
  logic timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES[0];
  assign timeout = 1'b0;
`endif

  // next state and the response captured on entry to RESP; completion beats timeout
  always_comb begin
    state_n = state;
    resp_data_n = resp_data_o;
    resp_op_n = resp_op_o;
    case (state)
      IDLE: if (accept) begin
        state_n = (req_op_i == OP_READ || req_op_i == OP_WRITE) ? ACCESS : RESP;
        resp_data_n = '0;
        resp_op_n = (req_op_i == OP_NOP) ? RESP_OK : RESP_FAIL;
      end
      ACCESS, WAIT: if (done) begin
        state_n = RESP;
        resp_data_n = cpl_data;
        resp_op_n = cpl_op;
      end else if (timeout) begin
        state_n = RESP;
        resp_data_n = '0;
        resp_op_n = RESP_FAIL;
      end else if (state == ACCESS && reg_gnt_i) state_n = WAIT;
      default: if (resp_ready_i) state_n = IDLE;
    endcase
  end

  // state, latched request and held response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      op_q <= '0;
      reg_addr_o <= '0;
      reg_wdata_o <= '0;
      resp_data_o <= '0;
      resp_op_o <= '0;
    end else begin
      state <= state_n;
      resp_data_o <= resp_data_n;
      resp_op_o <= resp_op_n;
      if (accept) begin
        op_q <= req_op_i;
        reg_addr_o <= req_addr_i;
        reg_wdata_o <= req_data_i;
      end
    end
  end
endmodule
